// File: rtl/tone_pkg.sv
// Shared types and constants for the polyphonic tone generator.
// Optional feature macro: POLY_TONEGEN_NOISE_EN (LFSR noise waveform).
package tone_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE  = 2'd0,
    WAVE_PULSE25 = 2'd1,
    WAVE_NOISE   = 2'd2,
    WAVE_OFF     = 2'd3
  } wave_e;

  // Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting right.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Octave-0 half-period dividers for C .. B.
  localparam logic [11:0] NOTE_TABLE [12] = '{
    12'd1468, 12'd1386, 12'd1308, 12'd1234, 12'd1165, 12'd1099,
    12'd1038, 12'd980,  12'd924,  12'd873,  12'd824,  12'd777
  };

  // Divider for a note/octave pair; invalid notes yield 0 (voice is silenced anyway).
  function automatic logic [11:0] note_div(input logic [3:0] note, input logic [2:0] octave);
    logic [11:0] base;
    base = 12'd0;
    if (note < 4'd12) base = NOTE_TABLE[note];
    return base >> octave;
  endfunction

endpackage

// File: rtl/tone_voice.sv
// One tone voice: phase counter, half-period flag and (optionally) a noise bit.
// Optional feature macro: POLY_TONEGEN_NOISE_EN (noise_bit flop and noise waveform).
// The level is taken from the state before the strobe update.
module tone_voice
  import tone_pkg::*;
#(
  parameter int VOL_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    strobe,
  input  logic                    enable,
  input  logic [3:0]              note,
  input  logic [2:0]              octave,
  input  logic [1:0]              wave_sel,
  input  logic [VOL_W-1:0]        volume,
  input  logic                    lfsr_bit,
  output logic signed [VOL_W:0]   level
);

  logic [11:0]            div;
  logic [11:0]            cnt;
  logic                   half;
  logic                   active;
  wave_e                  wave;
  logic signed [VOL_W:0]  pos_lvl;
  logic signed [VOL_W:0]  neg_lvl;

  assign div     = note_div(note, octave);
  assign active  = enable && (note < 4'd12);
  assign wave    = wave_e'(wave_sel);
  assign pos_lvl = $signed({1'b0, volume});
  assign neg_lvl = -pos_lvl;

  // Phase counter: '>=' lets a shrinking divider wrap on the next strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= 12'd0;
      half <= 1'b0;
    end else if (strobe) begin
      if (!active) begin
        cnt  <= 12'd0;
        half <= 1'b0;
      end else if (cnt >= div) begin
        cnt  <= 12'd0;
        half <= ~half;
      end else begin
        cnt  <= cnt + 12'd1;
      end
    end
  end

`ifdef POLY_TONEGEN_NOISE_EN
  logic noise_bit;

  // Noise bit resamples the shared LFSR at each half-period wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      noise_bit <= 1'b0;
    end else if (strobe && active && (cnt >= div)) begin
      noise_bit <= lfsr_bit;
    end
  end
`else
  logic unused_lfsr_bit;
  assign unused_lfsr_bit = lfsr_bit;
`endif

  // Waveform shaping of the current phase into a signed level.
  always_comb begin
    level = '0;
    if (active) begin
      unique case (wave)
        WAVE_SQUARE:  level = half ? pos_lvl : neg_lvl;
        WAVE_PULSE25: level = (half && (cnt <= (div >> 1))) ? pos_lvl : neg_lvl;
`ifdef POLY_TONEGEN_NOISE_EN
        WAVE_NOISE:   level = noise_bit ? pos_lvl : neg_lvl;
`else
        WAVE_NOISE:   level = '0;
`endif
        default:      level = '0;
      endcase
    end
  end

endmodule

// File: rtl/poly_tonegen.sv
// Polyphonic tone generator: strobe from the codec ready handshake, shared
// LFSR, per-voice tone_voice instances, mixer and registered sample output.
// Optional feature macro: POLY_TONEGEN_NOISE_EN (LFSR + noise waveform).
// Handshake: a strobe occurs when both ready inputs are high and
// sample_valid is low; sample_valid then stays high until either ready drops.
module poly_tonegen
  import tone_pkg::*;
#(
  parameter int VOICES   = 4,
  parameter int VOL_W    = 8,
  parameter int SAMPLE_W = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [VOICES-1:0]             voice_en,
  input  logic [VOICES-1:0][VOL_W-1:0]  volume,
  input  logic [VOICES-1:0][3:0]        note,
  input  logic [VOICES-1:0][2:0]        octave,
  input  logic [VOICES-1:0][1:0]        wave_sel,
  input  logic                          left_chan_ready,
  input  logic                          right_chan_ready,
  output logic [SAMPLE_W-1:0]           sample_data,
  output logic                          sample_valid
);

  if ((VOICES < 1) || (VOICES > 8)) begin : g_bad_voices
    $error("poly_tonegen: VOICES must be 1..8");
  end
  if (SAMPLE_W < VOL_W + 1 + $clog2(VOICES)) begin : g_bad_width
    $error("poly_tonegen: SAMPLE_W too narrow for VOICES and VOL_W");
  end

  logic                         both_ready;
  logic                         strobe;
  logic [VOICES-1:0]            lfsr_bits;
  logic signed [VOL_W:0]        level [VOICES];
  logic signed [SAMPLE_W-1:0]   mix;

  assign both_ready = left_chan_ready && right_chan_ready;
  assign strobe     = both_ready && !sample_valid;

`ifdef POLY_TONEGEN_NOISE_EN
  logic [15:0] lfsr;

  // Shared LFSR steps once per strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (strobe) begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign lfsr_bits = lfsr[VOICES-1:0];
`else
  assign lfsr_bits = '0;
`endif

  for (genvar g = 0; g < VOICES; g++) begin : g_voice
    tone_voice #(.VOL_W(VOL_W)) u_voice (
      .clk      (clk),
      .reset    (reset),
      .strobe   (strobe),
      .enable   (voice_en[g]),
      .note     (note[g]),
      .octave   (octave[g]),
      .wave_sel (wave_sel[g]),
      .volume   (volume[g]),
      .lfsr_bit (lfsr_bits[g]),
      .level    (level[g])
    );
  end

  // Mixer: sign-extend each level and sum; width rule rules out overflow.
  always_comb begin
    mix = '0;
    for (int v = 0; v < VOICES; v++) begin
      mix = mix + SAMPLE_W'(level[v]);
    end
  end

  // Output registers: capture the mix on strobe, drop valid when a ready falls.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_valid <= 1'b0;
      sample_data  <= '0;
    end else if (strobe) begin
      sample_valid <= 1'b1;
      sample_data  <= mix;
    end else if (!both_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_poly_tonegen.sv
// Bench for poly_tonegen: randomized and directed stimulus, a reference model
// of the tone rules feeding an expected queue, and an edge monitor that
// checks every cycle of the handshake against that queue.
module tb_poly_tonegen;

  localparam int VOICES   = 4;
  localparam int VOL_W    = 8;
  localparam int SAMPLE_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          reset = 1'b1;
  logic [VOICES-1:0]             voice_en = '0;
  logic [VOICES-1:0][VOL_W-1:0]  volume = '0;
  logic [VOICES-1:0][3:0]        note = '0;
  logic [VOICES-1:0][2:0]        octave = '0;
  logic [VOICES-1:0][1:0]        wave_sel = '0;
  logic                          left_chan_ready = 1'b0;
  logic                          right_chan_ready = 1'b0;
  logic [SAMPLE_W-1:0]           sample_data;
  logic                          sample_valid;

  poly_tonegen #(.VOICES(VOICES), .VOL_W(VOL_W), .SAMPLE_W(SAMPLE_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .voice_en         (voice_en),
    .volume           (volume),
    .note             (note),
    .octave           (octave),
    .wave_sel         (wave_sel),
    .left_chan_ready  (left_chan_ready),
    .right_chan_ready (right_chan_ready),
    .sample_data      (sample_data),
    .sample_valid     (sample_valid)
  );

  // ---------------- scoreboard state ----------------
  logic [SAMPLE_W-1:0] exp_q[$];
  logic [SAMPLE_W-1:0] got_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [SAMPLE_W-1:0] got, input logic [SAMPLE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t",
               name, $signed(got), got, $signed(exp), exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          note_tab [12] = '{1468, 1386, 1308, 1234, 1165, 1099, 1038, 980, 924, 873, 824, 777};
  int          m_phase [VOICES];
  bit          m_high [VOICES];
  bit          m_noise [VOICES];
  logic [15:0] m_lfsr;

  task automatic model_reset;
    for (int v = 0; v < VOICES; v++) begin
      m_phase[v] = 0;
      m_high[v]  = 0;
      m_noise[v] = 0;
    end
    m_lfsr = 16'hACE1;
  endtask

  // One strobe: emit the mix of the current phases, then advance every voice.
  task automatic push_expected;
    int mix;
    int lvl;
    int d;
    int vol;
    bit on;
    logic [31:0] mix_v;
    mix = 0;
    for (int v = 0; v < VOICES; v++) begin
      on  = voice_en[v] && (int'(note[v]) < 12);
      d   = on ? (note_tab[note[v]] >> octave[v]) : 0;
      vol = int'(volume[v]);
      lvl = 0;
      if (on) begin
        case (int'(wave_sel[v]))
          0: lvl = m_high[v] ? vol : -vol;
          1: lvl = (m_high[v] && (m_phase[v] <= d / 2)) ? vol : -vol;
`ifdef POLY_TONEGEN_NOISE_EN
          2: lvl = m_noise[v] ? vol : -vol;
`else
          2: lvl = 0;
`endif
          default: lvl = 0;
        endcase
      end
      mix += lvl;
    end
    mix_v = mix;
    exp_q.push_back(mix_v[SAMPLE_W-1:0]);
    for (int v = 0; v < VOICES; v++) begin
      on = voice_en[v] && (int'(note[v]) < 12);
      d  = on ? (note_tab[note[v]] >> octave[v]) : 0;
      if (!on) begin
        m_phase[v] = 0;
        m_high[v]  = 0;
      end else if (m_phase[v] >= d) begin
        m_phase[v] = 0;
        m_high[v]  = !m_high[v];
        m_noise[v] = m_lfsr[v];
      end else begin
        m_phase[v]++;
      end
    end
    if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
    else           m_lfsr = m_lfsr >> 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    left_chan_ready  = 1'b1;
    right_chan_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    push_expected();
    @(negedge clk);
    left_chan_ready  = 1'b0;
    right_chan_ready = 1'b0;
  endtask

  // hold: cycles both readies stay high; drop: 0 both, 1 left only, 2 right only.
  task automatic strobe_once(input int hold, input int drop);
    @(negedge clk);
    left_chan_ready  = 1'b1;
    right_chan_ready = 1'b1;
    push_expected();
    repeat (hold) @(negedge clk);
    if (drop != 2) left_chan_ready  = 1'b0;
    if (drop != 1) right_chan_ready = 1'b0;
  endtask

  task automatic run_strobes(input int n);
    for (int i = 0; i < n; i++) strobe_once(1, 0);
  endtask

  task automatic voices_off;
    voice_en = '0;
    volume   = '0;
    note     = '0;
    octave   = '0;
    wave_sel = '0;
  endtask

  task automatic check_got(input string name, input int idx, input int expv);
    logic [31:0] ev;
    ev = expv;
    if (idx >= got_q.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: sample %0d missing (only %0d captured)", name, idx, got_q.size());
    end else begin
      chk(name, got_q[idx], ev[SAMPLE_W-1:0]);
    end
  endtask

  // ---------------- monitor ----------------
  logic                prev_valid = 1'b0;
  logic [SAMPLE_W-1:0] prev_data = '0;

  always @(posedge clk) begin : monitor
    logic r;
    logic rs;
    logic [SAMPLE_W-1:0] e;
    r  = left_chan_ready && right_chan_ready;
    rs = reset;
    #1;
    if (rs) begin
      chk("reset_valid", {{(SAMPLE_W-1){1'b0}}, sample_valid}, '0);
      chk("reset_data", sample_data, '0);
    end else if (r && !prev_valid) begin
      chk("strobe_valid", {{(SAMPLE_W-1){1'b0}}, sample_valid}, {{(SAMPLE_W-1){1'b0}}, 1'b1});
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sample_unexpected: got %0d with no expected value queued", $signed(sample_data));
      end else begin
        e = exp_q.pop_front();
        chk("sample_data", sample_data, e);
      end
      got_q.push_back(sample_data);
    end else if (r) begin
      chk("hold_valid", {{(SAMPLE_W-1){1'b0}}, sample_valid}, {{(SAMPLE_W-1){1'b0}}, 1'b1});
      chk("hold_data", sample_data, prev_data);
    end else begin
      chk("drop_valid", {{(SAMPLE_W-1){1'b0}}, sample_valid}, '0);
      chk("idle_data", sample_data, prev_data);
    end
    prev_valid = sample_valid;
    prev_data  = sample_data;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int base;
    model_reset();

    // Reset held with both readies high; first strobe follows release.
    do_reset();

    // Single square voice: A, octave 0, vol 100 -> 874 low, 874 high.
    voices_off();
    voice_en[0] = 1'b1; note[0] = 4'd9; volume[0] = 8'd100;
    do_reset();
    base = got_q.size() - 1;
    run_strobes(1750);
    check_got("square_first",   base + 0,    -100);
    check_got("square_lastlow", base + 873,  -100);
    check_got("square_rise",    base + 874,   100);
    check_got("square_lasthi",  base + 1747,  100);
    check_got("square_fall",    base + 1748, -100);

    // Octave 3 -> half period 110.
    octave[0] = 3'd3;
    do_reset();
    base = got_q.size() - 1;
    run_strobes(230);
    check_got("oct3_lastlow", base + 109, -100);
    check_got("oct3_rise",    base + 110,  100);
    check_got("oct3_lasthi",  base + 219,  100);
    check_got("oct3_fall",    base + 220, -100);

    // Pulse25: note 11, vol 50 -> +50 for 389 of 1556.
    voices_off();
    voice_en[0] = 1'b1; note[0] = 4'd11; volume[0] = 8'd50; wave_sel[0] = 2'd1;
    do_reset();
    base = got_q.size() - 1;
    run_strobes(1560);
    check_got("pulse_low",     base + 777,  -50);
    check_got("pulse_rise",    base + 778,   50);
    check_got("pulse_lasthi",  base + 1166,  50);
    check_got("pulse_fall",    base + 1167, -50);
    check_got("pulse_period",  base + 1556, -50);

    // Mixing: 4 in-phase squares at vol 255, then voice2 silenced mid-run.
    voices_off();
    voice_en = '1;
    for (int v = 0; v < VOICES; v++) begin
      note[v] = 4'd9; octave[v] = 3'd3; volume[v] = 8'd255;
    end
    do_reset();
    base = got_q.size() - 1;
    run_strobes(119);
    check_got("mix_low",  base + 0,   -1020);
    check_got("mix_high", base + 110,  1020);
    note[2] = 4'd12;
    run_strobes(10);
    check_got("mix_silenced", base + 120, 765);
    note[2] = 4'd9;
    run_strobes(20);

    // Wrap: cnt reaches 1000 on note C, then switch to B (div 777).
    voices_off();
    voice_en[0] = 1'b1; note[0] = 4'd0; volume[0] = 8'd10;
    do_reset();
    base = got_q.size() - 1;
    run_strobes(999);
    note[0] = 4'd11;
    run_strobes(3);
    check_got("wrap_before", base + 1000, -10);
    check_got("wrap_toggle", base + 1001,  10);

    // Noise on voice0, fast divider.
    voices_off();
    voice_en[0] = 1'b1; note[0] = 4'd9; octave[0] = 3'd5; volume[0] = 8'd20; wave_sel[0] = 2'd2;
    voice_en[1] = 1'b1; note[1] = 4'd2; octave[1] = 3'd6; volume[1] = 8'd7;  wave_sel[1] = 2'd2;
    do_reset();
    base = got_q.size() - 1;
    run_strobes(300);
`ifdef POLY_TONEGEN_NOISE_EN
    check_got("noise_first", base + 0, -27);
`else
    check_got("noise_off_first", base + 0,   0);
    check_got("noise_off_late",  base + 250, 0);
`endif

    // Mid-operation reset while sample_valid is high.
    @(negedge clk);
    left_chan_ready = 1'b1; right_chan_ready = 1'b1;
    push_expected();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    left_chan_ready = 1'b0; right_chan_ready = 1'b0;
    model_reset();

    // Randomized configuration and handshake timing.
    voices_off();
    for (int i = 0; i < 700; i++) begin
      for (int v = 0; v < VOICES; v++) begin
        if ($urandom_range(0, 5) == 0) begin
          voice_en[v] = ($urandom_range(0, 3) != 0);
          note[v]     = 4'($urandom_range(0, 15));
          octave[v]   = 3'($urandom_range(2, 7));
          wave_sel[v] = 2'($urandom_range(0, 3));
          volume[v]   = 8'($urandom_range(0, 255));
        end
      end
      strobe_once($urandom_range(1, 3), $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Drain the expected queue with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected samples never produced", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/poly_tonegen.md
# poly_tonegen

Parametrised polyphonic tone generator for the audio codec path. It sums up to `VOICES` independent note voices into one signed sample stream. Each voice has its own note, octave, waveform and volume. It uses the same left/right ready handshake and the same octave-0 note divider table as the single-voice square generator, and adds per-voice enable, a 25% pulse wave and a compile-time noise mode.

## Interface
- `VOICES`, 4: number of voices, 1–8.
- `VOL_W`, 8: per-voice volume width, unsigned.
- `SAMPLE_W`, 16: output sample width, two's complement. Must be ≥ `VOL_W+1+$clog2(VOICES)`; elaboration fails otherwise.
- `clk` in 1: sole clock.
- `reset` in 1: reset, synchronous, active-high.
- `voice_en` in `VOICES`: per-voice enable.
- `volume` in `VOICES`×`VOL_W`: per-voice amplitude.
- `note` in `VOICES`×4: 0=C … 11=B; 12–15 invalid.
- `octave` in `VOICES`×3: right-shift applied to the divider.
- `wave_sel` in `VOICES`×2: 0 square, 1 pulse25, 2 noise, 3 off.
- `left_chan_ready` in 1: codec left channel ready.
- `right_chan_ready` in 1: codec right channel ready.
- `sample_data` out `SAMPLE_W`: mixed sample, registered.
- `sample_valid` out 1: sample handshake flag, registered.

## Operation
- **Strobe:** `strobe = left_chan_ready & right_chan_ready & ~sample_valid`. This gives one strobe per ready episode. All voice state advances only on a strobe.
- **Divider:** `div = NOTE_TABLE[note] >> octave`, 12 bits. The octave-0 table is 1468, 1386, 1308, 1234, 1165, 1099, 1038, 980, 924, 873, 824, 777.
- **Per-voice state:**
  - 12-bit `cnt`.
  - 1-bit `half`.
  - 1-bit `noise_bit`.
- **Voice update on strobe:**
  - If `cnt >= div`, then `cnt <= 0`, `half <= ~half`, and `noise_bit <= lfsr[v]` (bit v of the shared LFSR).
  - Otherwise `cnt <= cnt+1`.
  - Using `>=` means a note or octave change that drops `div` below `cnt` wraps on the next strobe, with no 4096-count runaway.
- **Voice level:**
  - square: `+vol` if `half`, else `-vol`.
  - pulse25: `+vol` if `half & (cnt <= div>>1)`, else `-vol`.
  - noise: `+vol` if `noise_bit`, else `-vol`.
  - off: 0.
- **Silenced voices** (`voice_en=0`, or `note>=12`):
  - level is 0;
  - `cnt` is held at 0 and `half` at 0, so the voice restarts phase-aligned when re-enabled.
- **Mixing:** the sample is the sum of all voice levels. Each level is `VOL_W+1` bits signed, sign-extended to `SAMPLE_W`. There is no saturation; the width rule guarantees no overflow.
- **Level source:** `sample_data` is computed from the voice state before the strobe update, i.e. the current phase is emitted and then advanced.
- **LFSR:** 16-bit Galois, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1. It steps once per strobe.

## Timing
- **Reset:** synchronous and dominant over all other inputs. On the clock edge with `reset=1`:
  - `sample_valid=0`, `sample_data=0`;
  - every `cnt=0`, `half=0`, `noise_bit=0`;
  - `lfsr=16'hACE1`.
- **Mid-operation reset:** reset asserted while `sample_valid=1` clears it on that edge.
- **Strobe in cycle t:** at the t+1 edge, `sample_data` takes the new mix, `sample_valid` goes to 1, and voice state advances. Latency is 1 clock.
- **`sample_valid` hold and drop:**
  - stays 1 while both ready inputs are high;
  - drops to 0 the edge after either ready input is low.
  - `sample_data` holds its value until the next strobe.
- **Input sampling:** inputs are sampled at the strobe edge only. Changes between strobes have no effect until the next strobe.
- **Minimum strobe spacing:** 2 clocks (ready high, low, high).

## Configuration
- **`POLY_TONEGEN_NOISE_EN` defined:** LFSR and per-voice `noise_bit` are compiled in, and `wave_sel=2` selects noise.
- **Undefined:**
  - no LFSR or `noise_bit` flops;
  - `wave_sel=2` behaves exactly as off (level 0), while the counters still run.

## Structure
- **Package `tone_pkg`:**
  - `NOTE_TABLE` (12×12-bit);
  - `wave_e` enum (`WAVE_SQUARE`, `WAVE_PULSE25`, `WAVE_NOISE`, `WAVE_OFF`);
  - `LFSR_SEED`, `LFSR_TAPS`.
- **Sub-module `tone_voice`:** one per voice, instantiated in a generate loop. It holds `cnt`/`half`/`noise_bit`, takes `strobe` and `lfsr_bit` as inputs, and outputs a signed `VOL_W+1` level.
- **Top level:** holds the strobe logic, the LFSR, the adder tree and the output registers.

## Test plan
- **Reset:** hold `reset` 3 clocks while both ready inputs are high → `sample_valid=0` and `sample_data=0` throughout; first strobe after release gives `sample_valid=1` one clock later.
- **Single square voice:** voice0 enabled, note 9 (A), octave 0, vol 100, one strobe per ready episode → `sample_data` is −100 for 874 samples, then +100 for 874, repeating.
- **Octave shift:** same voice at octave 3 → half-period 110 samples (`div`=109).
- **Pulse25:** voice0 pulse25, note 11, octave 0, vol 50 → per 1556-sample period, +50 for 389 samples and −50 for 1167.
- **Mixing and width:** 4 voices square, vol 255, all in phase → sample alternates between −1020 and +1020. Changing voice2 to note 12 mid-run → mix becomes ±765 on the next strobe.
- **Wrap and noise:**
  - With `cnt` at 1000, switch note from 0 to 11 → toggle on the very next strobe.
  - With `POLY_TONEGEN_NOISE_EN`, noise mode samples follow LFSR bit v starting from seed 16'hACE1.
  - Without the macro, noise mode gives constant 0.
